// File: rtl/demux_slot.sv
// One-entry output register for a single demux channel.
// Loads when the parent asserts load; drains on a valid/ready handshake.
module demux_slot #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              can_accept
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    // A full slot that is draining this cycle may reload in the same cycle.
    assign can_accept = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/stream_demux_reg.sv
// Registered 1-to-N stream demultiplexer with broadcast and a saturating
// counter of beats dropped because their select was out of range.
module stream_demux_reg #(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned N_OUT  = 4,
    parameter  int unsigned CNT_W  = 8,
    localparam int unsigned SEL_W  = ($clog2(N_OUT) > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_bcast,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]        drop_count
);

    logic [N_OUT-1:0] sel_hit;
    logic [N_OUT-1:0] can_accept;
    logic [N_OUT-1:0] load;
    logic             unicast_hit;
    logic             accept;
    logic             drop;
    logic [CNT_W-1:0] drop_q, drop_d;

    // A unicast select matching no channel is out of range: always accepted, then dropped.
    always_comb begin
        for (int k = 0; k < int'(N_OUT); k++) begin
            sel_hit[k] = !in_bcast && (in_sel == SEL_W'(k));
        end
        unicast_hit = |sel_hit;

        if (in_bcast) begin
            in_ready = &can_accept;
        end else if (unicast_hit) begin
            in_ready = |(sel_hit & can_accept);
        end else begin
            in_ready = 1'b1;
        end

        accept = in_valid && in_ready;
        load   = '0;
        if (accept) begin
            load = in_bcast ? '1 : sel_hit;
        end
        drop = accept && !in_bcast && !unicast_hit;
    end

    always_comb begin
        drop_d = drop_q;
        if (drop && (drop_q != '1)) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        demux_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (load[k]),
            .load_data  (in_data),
            .out_valid  (out_valid[k]),
            .out_ready  (out_ready[k]),
            .out_data   (out_data[k*DATA_W +: DATA_W]),
            .can_accept (can_accept[k])
        );
    end

endmodule

// File: tb/tb_stream_demux_reg.sv
// Scoreboard bench: a 4-channel instance for data path checks and a 3-channel
// instance with a 2-bit counter for out-of-range drop accounting.
module tb_stream_demux_reg;

    logic        clk;
    logic        rst_n;

    logic        a_in_valid, a_in_ready, a_in_bcast;
    logic [7:0]  a_in_data;
    logic [1:0]  a_in_sel;
    logic [3:0]  a_out_valid, a_out_ready;
    logic [31:0] a_out_data;
    logic [7:0]  a_drop_count;

    logic        b_in_valid, b_in_ready, b_in_bcast;
    logic [7:0]  b_in_data;
    logic [1:0]  b_in_sel;
    logic [2:0]  b_out_valid, b_out_ready;
    logic [23:0] b_out_data;
    logic [1:0]  b_drop_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q [4][$];

    stream_demux_reg #(
        .DATA_W (8),
        .N_OUT  (4),
        .CNT_W  (8)
    ) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .in_data    (a_in_data),
        .in_sel     (a_in_sel),
        .in_bcast   (a_in_bcast),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .out_data   (a_out_data),
        .drop_count (a_drop_count)
    );

    stream_demux_reg #(
        .DATA_W (8),
        .N_OUT  (3),
        .CNT_W  (2)
    ) u_dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_data    (b_in_data),
        .in_sel     (b_in_sel),
        .in_bcast   (b_in_bcast),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_data   (b_out_data),
        .drop_count (b_drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [7:0] d, input logic [1:0] s, input logic b);
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_sel   = s;
        a_in_bcast = b;
    endtask

    task automatic idle_a();
        a_in_valid = 1'b0;
        a_in_bcast = 1'b0;
    endtask

    // Monitor: inputs only change just after posedge, so the negedge view equals
    // what the DUT sees at the following edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (a_out_valid[k] && a_out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        chk($sformatf("unexpected_beat_ch%0d", k), {56'd0, a_out_data[k*8 +: 8]},
                            64'hdead);
                    end else begin
                        chk($sformatf("scoreboard_ch%0d", k), {56'd0, a_out_data[k*8 +: 8]},
                            {56'd0, exp_q[k].pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        a_in_valid  = 1'b0;
        a_in_bcast  = 1'b0;
        a_in_data   = '0;
        a_in_sel    = '0;
        a_out_ready = 4'hF;
        b_in_valid  = 1'b0;
        b_in_bcast  = 1'b0;
        b_in_data   = '0;
        b_in_sel    = '0;
        b_out_ready = 3'h7;

        #3;
        chk("reset_valid", {60'd0, a_out_valid}, 64'd0);
        chk("reset_data", {32'd0, a_out_data}, 64'd0);
        chk("reset_drop", {56'd0, a_drop_count}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Unicast sweep: each channel pulses one cycle after its beat.
        for (int k = 0; k < 4; k++) begin
            drive_a(8'hA0 + 8'(k), 2'(k), 1'b0);
            #1;
            chk($sformatf("sweep_in_ready_%0d", k), {63'd0, a_in_ready}, 64'd1);
            exp_q[k].push_back(8'hA0 + 8'(k));
            tick();
            chk($sformatf("sweep_valid_%0d", k), {60'd0, a_out_valid}, 64'd1 << k);
        end
        idle_a();
        tick();
        chk("sweep_drained", {60'd0, a_out_valid}, 64'd0);

        // Backpressure on channel 1.
        a_out_ready[1] = 1'b0;
        drive_a(8'h11, 2'd1, 1'b0);
        #1;
        chk("bp_first_ready", {63'd0, a_in_ready}, 64'd1);
        exp_q[1].push_back(8'h11);
        tick();
        drive_a(8'h22, 2'd1, 1'b0);
        #1;
        chk("bp_second_blocked", {63'd0, a_in_ready}, 64'd0);
        tick();
        chk("bp_hold_valid", {63'd0, a_out_valid[1]}, 64'd1);
        chk("bp_hold_data", {56'd0, a_out_data[15:8]}, 64'h11);
        chk("bp_still_blocked", {63'd0, a_in_ready}, 64'd0);
        a_out_ready[1] = 1'b1;
        #1;
        chk("bp_release_ready", {63'd0, a_in_ready}, 64'd1);
        exp_q[1].push_back(8'h22);
        tick();
        idle_a();
        chk("bp_reload_valid", {63'd0, a_out_valid[1]}, 64'd1);
        chk("bp_reload_data", {56'd0, a_out_data[15:8]}, 64'h22);
        tick();

        // Broadcast blocked by a full channel 3, then all-at-once delivery.
        a_out_ready[3] = 1'b0;
        drive_a(8'h33, 2'd3, 1'b0);
        exp_q[3].push_back(8'h33);
        tick();
        drive_a(8'h5A, 2'd0, 1'b1);
        #1;
        chk("bcast_blocked", {63'd0, a_in_ready}, 64'd0);
        tick();
        chk("bcast_no_partial", {60'd0, a_out_valid}, 64'h8);
        a_out_ready[3] = 1'b1;
        #1;
        chk("bcast_release_ready", {63'd0, a_in_ready}, 64'd1);
        for (int k = 0; k < 4; k++) exp_q[k].push_back(8'h5A);
        tick();
        idle_a();
        chk("bcast_all_valid", {60'd0, a_out_valid}, 64'hF);
        chk("bcast_all_data", {32'd0, a_out_data}, 64'h5A5A5A5A);
        tick();

        // Throughput: one beat per cycle to channel 0.
        for (int i = 0; i < 16; i++) begin
            drive_a(8'h40 + 8'(i), 2'd0, 1'b0);
            #1;
            chk($sformatf("tput_ready_%0d", i), {63'd0, a_in_ready}, 64'd1);
            exp_q[0].push_back(8'h40 + 8'(i));
            tick();
            chk($sformatf("tput_valid_%0d", i), {63'd0, a_out_valid[0]}, 64'd1);
        end
        idle_a();
        tick();
        tick();
        chk("no_drops_pow2", {56'd0, a_drop_count}, 64'd0);

        // Out-of-range select on the 3-channel instance: drop counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            b_in_valid = 1'b1;
            b_in_sel   = 2'd3;
            b_in_data  = 8'(i);
            #1;
            chk($sformatf("drop_ready_%0d", i), {63'd0, b_in_ready}, 64'd1);
            tick();
            chk($sformatf("drop_no_valid_%0d", i), {61'd0, b_out_valid}, 64'd0);
            chk($sformatf("drop_count_%0d", i), {62'd0, b_drop_count}, (i < 3) ? 64'(i + 1) : 64'd3);
        end
        b_in_valid = 1'b0;

        for (int k = 0; k < 4; k++) begin
            chk($sformatf("queue_empty_ch%0d", k), 64'(exp_q[k].size()), 64'd0);
        end

        // Asynchronous reset mid-stream with channel 2 holding a beat.
        a_out_ready[2] = 1'b0;
        drive_a(8'h77, 2'd2, 1'b0);
        tick();
        idle_a();
        chk("pre_reset_valid", {60'd0, a_out_valid}, 64'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", {60'd0, a_out_valid}, 64'd0);
        chk("async_reset_data", {32'd0, a_out_data}, 64'd0);
        chk("async_reset_drop3", {62'd0, b_drop_count}, 64'd0);
        chk("async_reset_drop4", {56'd0, a_drop_count}, 64'd0);
        tick();
        rst_n = 1'b1;
        a_out_ready = 4'hF;
        tick();
        chk("post_reset_idle", {60'd0, a_out_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
